// File: rtl/gemm_pkg.sv
// Shared GeMM definitions: default datapath widths and the result-writer state type.
package gemm_pkg;

    localparam int unsigned DefAddrWidth = 16;
    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefFifoDepth = 4;

    typedef enum logic [1:0] {
        WriterIdle,
        WriterBusy,
        WriterDrain,
        WriterFinish
    } writer_state_t;

endpackage

// File: rtl/result_fifo.sv
// Registered synchronous FIFO (no fall-through) buffering GeMM results ahead of memory C.
module result_fifo #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      cnt_q;
    logic                 do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Storage carries no reset; the head is only meaningful while not empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/gemm_result_writer.sv
// Collects GeMM result elements and writes them row-major to memory C, pulsing done_o at the end.
module gemm_result_writer
    import gemm_pkg::*;
#(
    parameter int unsigned AddrWidth = DefAddrWidth,
    parameter int unsigned DataWidth = DefDataWidth,
    parameter int unsigned FifoDepth = DefFifoDepth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] M_size_i,
    input  logic [AddrWidth-1:0] N_size_i,
    input  logic [AddrWidth-1:0] C_base_addr_i,
    input  logic                 result_valid_i,
    input  logic [DataWidth-1:0] result_data_i,
    output logic                 result_ready_o,
    output logic                 mem_req_valid_o,
    input  logic                 mem_req_ready_i,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic [AddrWidth-1:0] M_count_o,
    output logic [AddrWidth-1:0] N_count_o,
    output logic                 busy_o,
    output logic                 done_o
);

    writer_state_t        state_q;
    logic [AddrWidth-1:0] m_size_q, n_size_q;
    logic [AddrWidth-1:0] acc_m_q, acc_n_q;
    logic [AddrWidth-1:0] wr_m_q, wr_n_q;
    logic [AddrWidth-1:0] addr_q;
    logic                 busy_q, done_q;

    logic                 fifo_full, fifo_empty;
    logic [DataWidth-1:0] fifo_head;
    logic                 accept, handshake;
    logic                 acc_n_last, acc_m_last, wr_n_last;

    assign result_ready_o  = (state_q == WriterBusy) && !fifo_full;
    assign accept          = result_valid_i && result_ready_o;
    assign mem_req_valid_o = ((state_q == WriterBusy) || (state_q == WriterDrain)) && !fifo_empty;
    assign handshake       = mem_req_valid_o && mem_req_ready_i;

    // Gate the head so stale storage never leaks onto the bus while idle or after reset.
    assign mem_wdata_o = mem_req_valid_o ? fifo_head : '0;
    assign mem_addr_o  = addr_q;
    assign M_count_o   = wr_m_q;
    assign N_count_o   = wr_n_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

    assign acc_n_last = (acc_n_q == n_size_q - AddrWidth'(1));
    assign acc_m_last = (acc_m_q == m_size_q - AddrWidth'(1));
    assign wr_n_last  = (wr_n_q == n_size_q - AddrWidth'(1));

    result_fifo #(
        .DataWidth (DataWidth),
        .Depth     (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accept),
        .data_i  (result_data_i),
        .pop_i   (handshake),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= WriterIdle;
            m_size_q <= '0;
            n_size_q <= '0;
            acc_m_q  <= '0;
            acc_n_q  <= '0;
            wr_m_q   <= '0;
            wr_n_q   <= '0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Write side: the address register stands in for base + m*N + n.
            if (handshake) begin
                addr_q <= addr_q + AddrWidth'(1);
                if (wr_n_last) begin
                    wr_n_q <= '0;
                    wr_m_q <= wr_m_q + AddrWidth'(1);
                end else begin
                    wr_n_q <= wr_n_q + AddrWidth'(1);
                end
            end

            case (state_q)
                WriterIdle: begin
                    if (start_i) begin
                        m_size_q <= M_size_i;
                        n_size_q <= N_size_i;
                        addr_q   <= C_base_addr_i;
                        acc_m_q  <= '0;
                        acc_n_q  <= '0;
                        wr_m_q   <= '0;
                        wr_n_q   <= '0;
                        if ((M_size_i == '0) || (N_size_i == '0)) begin
                            state_q <= WriterFinish;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= WriterBusy;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                WriterBusy: begin
                    if (accept) begin
                        if (acc_n_last) begin
                            acc_n_q <= '0;
                            if (acc_m_last) begin
                                state_q <= WriterDrain;
                            end else begin
                                acc_m_q <= acc_m_q + AddrWidth'(1);
                            end
                        end else begin
                            acc_n_q <= acc_n_q + AddrWidth'(1);
                        end
                    end
                end
                WriterDrain: begin
                    if (fifo_empty) begin
                        state_q <= WriterFinish;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                WriterFinish: begin
                    state_q <= WriterIdle;
                    acc_m_q <= '0;
                    acc_n_q <= '0;
                    wr_m_q  <= '0;
                    wr_n_q  <= '0;
                    addr_q  <= '0;
                end
                default: state_q <= WriterIdle;
            endcase
        end
    end

endmodule
